// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a 16-bit-addressed 24C-style EEPROM with a local preload port.
// Define EEPROM_WRITE_PROTECT_EN to NACK and discard I2C data writes (ld port still writes).
module i2c_eeprom_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'h50,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              busy,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr
);

`ifdef EEPROM_WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, ADDR_HI, ACK_HI, ADDR_LO, ACK_LO,
        WR_DATA, ACK_WR, RD_DATA, RD_ACK
    } state_t;

    // bit 0 = SCL, bit 1 = SDA
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [FW-1:0] fcnt [2];
    logic          sda_in;

    assign sda_in = sda;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            filt_d  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {sda_in, scl};
            sync2  <= sync1;
            filt_d <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_c, stop_c;
    assign scl_f    = filt[0];
    assign sda_f    = filt[1];
    assign scl_rise = scl_f & ~filt_d[0];
    assign scl_fall = ~scl_f & filt_d[0];
    assign start_c  = scl_f & filt_d[0] & filt_d[1] & ~sda_f;
    assign stop_c   = scl_f & filt_d[0] & ~filt_d[1] & sda_f;

    state_t            state, state_n;
    logic [2:0]        bit_cnt, cnt_n;
    logic [7:0]        shreg, sh_n, addr_hi, hi_n, rdata, byte_in;
    logic [ADDR_W-1:0] ptr, ptr_n, wa_n;
    logic              rw, rw_n, wr_en, pulse_n, drive, oe, fall_d;

    logic [7:0] mem [2**ADDR_W];

    assign byte_in = {shreg[6:0], sda_f};

    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        sh_n    = shreg;
        hi_n    = addr_hi;
        ptr_n   = ptr;
        rw_n    = rw;
        wa_n    = wr_addr;
        wr_en   = 1'b0;
        pulse_n = 1'b0;
        if (start_c) begin
            state_n = DEVADDR;
            cnt_n   = '0;
        end else if (stop_c) begin
            state_n = IDLE;
        end else if (scl_rise) begin
            // All transitions happen on SCL rising; SDA only follows on the next falling edge.
            case (state)
                DEVADDR: begin
                    sh_n  = byte_in;
                    cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rw_n    = byte_in[0];
                        state_n = (byte_in[7:1] == DEV_ADDR) ? ACK_DEV : IDLE;
                    end
                end
                ACK_DEV: begin
                    if (rw) begin
                        state_n = RD_DATA;
                        sh_n    = rdata;
                    end else begin
                        state_n = ADDR_HI;
                    end
                end
                ADDR_HI: begin
                    sh_n  = byte_in;
                    cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        hi_n    = byte_in;
                        state_n = ACK_HI;
                    end
                end
                ACK_HI:  state_n = ADDR_LO;
                ADDR_LO: begin
                    sh_n  = byte_in;
                    cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ptr_n   = ADDR_W'({addr_hi, byte_in});
                        state_n = ACK_LO;
                    end
                end
                ACK_LO:  state_n = WR_DATA;
                WR_DATA: begin
                    sh_n  = byte_in;
                    cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = ACK_WR;
                        if (!WP) begin
                            wr_en   = 1'b1;
                            pulse_n = 1'b1;
                            wa_n    = ptr;
                            ptr_n   = ptr + ADDR_W'(1);
                        end
                    end
                end
                ACK_WR:  state_n = WR_DATA;
                RD_DATA: begin
                    sh_n  = {shreg[6:0], 1'b1};
                    cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ptr_n   = ptr + ADDR_W'(1);
                        state_n = RD_ACK;
                    end
                end
                RD_ACK: begin
                    if (!sda_f) begin
                        state_n = RD_DATA;
                        sh_n    = rdata;
                    end else begin
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        drive = 1'b0;
        case (state)
            ACK_DEV, ACK_HI, ACK_LO: drive = 1'b1;
            ACK_WR:                  drive = !WP;
            RD_DATA:                 drive = ~shreg[7];
            default:                 drive = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            addr_hi  <= '0;
            ptr      <= '0;
            rw       <= 1'b0;
            busy     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            oe       <= 1'b0;
            fall_d   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= cnt_n;
            shreg    <= sh_n;
            addr_hi  <= hi_n;
            ptr      <= ptr_n;
            rw       <= rw_n;
            wr_pulse <= pulse_n;
            wr_addr  <= wa_n;
            fall_d   <= scl_fall;
            if (start_c)
                busy <= 1'b1;
            else if (stop_c)
                busy <= 1'b0;
            // SDA updates two clk after the filtered SCL falling edge.
            if (start_c || stop_c)
                oe <= 1'b0;
            else if (fall_d)
                oe <= drive;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_we)
            mem[ld_addr] <= ld_data;
        else if (wr_en)
            mem[ptr] <= byte_in;
        rdata <= mem[ptr];
    end

    assign sda = oe ? 1'b0 : 1'bz;

endmodule
